grn_node_lut: RTL and testbench

- Parametrised Boolean gene-regulatory-network node for the GNR attractor search fabric.
- Holds two copies of one node state: s0 is the slow "tortoise" copy and advances once every S0_DIV accepted start_s0 pulses; s1 is the fast "hare" copy and advances on every start_s1.
- The next-state function is a runtime-programmable truth table over K regulator inputs, not a fixed expression.
- Also provides a per-node s0/s1 match flag and a saturating flip counter on s1 for convergence monitoring.

---
 rtl/grn_node_lut.sv | 70 +++++++
 tb/tb_grn_node_lut.sv | 127 ++++++++++++
 2 files changed

// File: rtl/grn_node_lut.sv
// grn_node_lut: Boolean GRN node with programmable truth table, slow/fast state copies and s1 flip counter
module grn_node_lut #(
   parameter int K = 2,
   parameter int S0_DIV = 2,
   parameter logic [(1<<K)-1:0] LUT_INIT = '0,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                reset_nos,
   input  logic                init_state,
   input  logic                start_s0,
   input  logic                start_s1,
   input  logic [K-1:0]        regs_s0,
   input  logic [K-1:0]        regs_s1,
   input  logic                cfg_we,
   input  logic [(1<<K)-1:0]   cfg_lut,
   output logic                s0,
   output logic                s1,
   output logic                node_s0,
   output logic                node_s1,
   output logic                match,
   output logic [CNT_W-1:0]    flips,
   output logic [(1<<K)-1:0]   lut_q
);
   localparam int DW = (S0_DIV > 1) ? $clog2(S0_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(S0_DIV - 1);

   logic [(1<<K)-1:0] lut;
   logic [DW-1:0]     div_cnt;
   logic              nxt_s1;

   assign nxt_s1  = lut[regs_s1];
   assign node_s0 = s0;
   assign node_s1 = s1;
   assign match   = s0 == s1;
   assign lut_q   = lut;

   // State update: rst, then network re-init, then start-driven advances; table writes act after indexing
   always_ff @(posedge clk) begin
      if (rst) begin
         s0      <= 1'b0;
         s1      <= 1'b0;
         flips   <= '0;
         lut     <= LUT_INIT;
         div_cnt <= DIV_MAX;
      end else begin
         if (reset_nos) begin
            s0      <= init_state;
            s1      <= init_state;
            flips   <= '0;
            div_cnt <= '0;
         end else begin
            if (start_s0) begin
               if (div_cnt == '0) begin
                  s0      <= lut[regs_s0];
                  div_cnt <= DIV_MAX;
               end else begin
                  div_cnt <= div_cnt - 1'b1;
               end
            end
            if (start_s1) begin
               s1 <= nxt_s1;
               if (nxt_s1 != s1 && flips != '1) flips <= flips + 1'b1;
            end
         end
         if (cfg_we) lut <= cfg_lut;
      end
   end
endmodule

// File: tb/tb_grn_node_lut.sv
// tb_grn_node_lut: directed stimulus with per-cycle model comparison for grn_node_lut
module tb_grn_node_lut;
   localparam int K = 2;
   localparam int S0_DIV = 2;
   localparam int CNT_W = 4;

   logic clk = 0, rst = 1, reset_nos = 0, init_state = 0, start_s0 = 0, start_s1 = 0, cfg_we = 0;
   logic [K-1:0] regs_s0 = '0, regs_s1 = '0;
   logic [3:0] cfg_lut = '0;
   logic s0, s1, node_s0, node_s1, match;
   logic [CNT_W-1:0] flips;
   logic [3:0] lut_q;

   int checks = 0, errors = 0;

   grn_node_lut #(.K(K), .S0_DIV(S0_DIV), .LUT_INIT(4'b1000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .reset_nos(reset_nos), .init_state(init_state),
      .start_s0(start_s0), .start_s1(start_s1), .regs_s0(regs_s0), .regs_s1(regs_s1),
      .cfg_we(cfg_we), .cfg_lut(cfg_lut), .s0(s0), .s1(s1), .node_s0(node_s0),
      .node_s1(node_s1), .match(match), .flips(flips), .lut_q(lut_q)
   );

   always #5 clk = ~clk;

   // Reference model: pulse counting since the last (re)initialisation decides which start_s0 updates
   bit m_valid = 0;
   bit m_s0, m_s1;
   int m_flips, m_n, m_off;
   logic [3:0] m_lut;
   always @(posedge clk) begin
      if (rst) begin
         m_valid = 1; m_s0 = 0; m_s1 = 0; m_flips = 0; m_lut = 4'b1000; m_n = 0; m_off = 1;
      end else begin
         if (reset_nos) begin
            m_s0 = init_state; m_s1 = init_state; m_flips = 0; m_n = 0; m_off = 0;
         end else begin
            if (start_s0) begin
               if ((m_n + m_off) % S0_DIV == 0) m_s0 = m_lut[regs_s0];
               m_n++;
            end
            if (start_s1) begin
               if (m_lut[regs_s1] != m_s1 && m_flips < (1 << CNT_W) - 1) m_flips++;
               m_s1 = m_lut[regs_s1];
            end
         end
         if (cfg_we) m_lut = cfg_lut;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model
   always @(negedge clk) if (m_valid) begin
      chk("s0", int'(s0), int'(m_s0));
      chk("s1", int'(s1), int'(m_s1));
      chk("node_s0", int'(node_s0), int'(m_s0));
      chk("node_s1", int'(node_s1), int'(m_s1));
      chk("match", int'(match), int'(m_s0 == m_s1));
      chk("flips", int'(flips), m_flips);
      chk("lut_q", int'(lut_q), int'(m_lut));
   end

   task automatic tick;
      @(negedge clk);
      #1;
      rst = 0; reset_nos = 0; start_s0 = 0; start_s1 = 0; cfg_we = 0;
   endtask

   initial begin
      rst = 1; tick;
      chk("rst_s0", int'(s0), 0);
      chk("rst_s1", int'(s1), 0);
      chk("rst_flips", int'(flips), 0);
      chk("rst_lut", int'(lut_q), 4'b1000);
      tick;
      regs_s0 = 2'b11; start_s0 = 1; tick;
      chk("rst_skip_first", int'(s0), 0);
      start_s0 = 1; tick;
      chk("rst_second_upd", int'(s0), 1);
      reset_nos = 1; init_state = 1; tick;
      chk("nos_s0", int'(s0), 1);
      chk("nos_s1", int'(s1), 1);
      chk("nos_flips", int'(flips), 0);
      chk("nos_match", int'(match), 1);
      chk("nos_lut", int'(lut_q), 4'b1000);
      regs_s0 = 2'b01; start_s0 = 1; tick;
      chk("div_p1", int'(s0), 0);
      start_s0 = 1; tick;
      chk("div_p2", int'(s0), 0);
      regs_s0 = 2'b11; start_s0 = 1; tick;
      chk("div_p3", int'(s0), 1);
      regs_s0 = 2'b01; start_s0 = 1; tick;
      chk("div_p4_hold", int'(s0), 1);
      tick; tick;
      reset_nos = 1; init_state = 0; tick;
      cfg_we = 1; cfg_lut = 4'b0110; regs_s1 = 2'b01; start_s1 = 1; tick;
      chk("cfg_old_tbl_s1", int'(s1), 0);
      chk("cfg_old_tbl_flips", int'(flips), 0);
      chk("cfg_lut_q", int'(lut_q), 4'b0110);
      start_s1 = 1; tick;
      chk("cfg_new_tbl_s1", int'(s1), 1);
      chk("cfg_new_tbl_flips", int'(flips), 1);
      for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
         regs_s1 = (i % 2 == 0) ? 2'b00 : 2'b01;
         start_s1 = 1; tick;
      end
      chk("sat_flips", int'(flips), 15);
      reset_nos = 1; init_state = 0; tick;
      chk("sat_clear", int'(flips), 0);
      reset_nos = 1; init_state = 1; regs_s0 = 2'b00; regs_s1 = 2'b00;
      start_s0 = 1; start_s1 = 1; tick;
      chk("nos_ovr_s0", int'(s0), 1);
      chk("nos_ovr_s1", int'(s1), 1);
      start_s0 = 1; tick;
      chk("nos_next_s0", int'(s0), 0);
      chk("nos_next_match", int'(match), 0);
      tick; tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
